// File: rtl/cpu_pkg.sv
// Shared constants and types for the 4-bit CPU datapath.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 4;
    localparam int CPU_DATA_W  = 4;
    localparam int CPU_INSTR_W = 2 * CPU_DATA_W;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

    typedef enum logic [1:0] {
        S_OP,
        S_ARG,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// RAM read port plus decoder handshake as seen by the fetch stage.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
);
    // RAM side
    logic              ram_csn;
    logic              ram_rwn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_out;

    // decoder side
    logic [2*DATA_W-1:0] instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [ADDR_W-1:0]   instr_pc;

    modport master (
        output ram_csn, ram_rwn, ram_addr, instr, instr_valid, instr_pc,
        input  ram_data_out, instr_ready
    );

    modport slave (
        input  ram_csn, ram_rwn, ram_addr, instr, instr_valid, instr_pc,
        output ram_data_out, instr_ready
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: load on jump, +2 per fetched instruction, wraps at ADDR_W.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_p1
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next PC: a load beats the increment; arithmetic truncates naturally.
    always_comb begin
        pc_d = pc_q;
        if (load)
            pc_d = load_addr;
        else if (inc)
            pc_d = pc_q + ADDR_W'(2);
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc    = pc_q;
    assign pc_p1 = pc_q + ADDR_W'(1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode@pc and operand@pc+1 from the RAM and
// presents {opcode, operand} to the decoder over valid/ready.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              mem_busy,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    fetch_unit_if.master      bus
);

    fetch_state_e          state_q, state_d;
    logic [DATA_W-1:0]     opcode_q, opcode_d;
    logic [2*DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]     instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;

    logic [ADDR_W-1:0]     pc, pc_p1;
    logic                  pc_inc;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;

    pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (jump_en),
        .load_addr (jump_addr),
        .inc       (pc_inc),
        .pc        (pc),
        .pc_p1     (pc_p1)
    );

    // FSM next state, read request and output register updates.
    // A jump always loads the PC (the counter handles that) and aborts work.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_inc        = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = pc;
        case (state_q)
            S_OP: begin
                if (!jump_en && !halt && !mem_busy) begin
                    rd_en    = 1'b1;
                    opcode_d = bus.ram_data_out;
                    state_d  = S_ARG;
                end
            end
            S_ARG: begin
                rd_addr = pc_p1;
                if (jump_en) begin
                    state_d = S_OP;
                end else if (!mem_busy) begin
                    rd_en         = 1'b1;
                    instr_d       = {opcode_q, bus.ram_data_out};
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    pc_inc        = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                // jump drops the held instruction even if it is being accepted
                if (jump_en || bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    // State and output registers; reset discards any partial opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OP;
            opcode_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Reset overrides any read request so the RAM stays deselected.
    assign bus.ram_csn     = !(rd_en && !rst);
    assign bus.ram_addr    = (rd_en && !rst) ? rd_addr : '0;
    assign bus.ram_rwn     = 1'b1;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule
